if_block: RTL

- Instruction-fetch stage; writer side of the decode-stage input interface.
- Owns the fetch PC, selects the next PC from the redirect sources, and drives the synchronous instruction memory read port.
- Presents a stable {de_reg, ir} pair to the decode stage, holding it across hazard stalls and inserting NOP bubbles on flushes.

---
 rtl/if_block_pkg.sv | 26 ++
 rtl/if_block_next_pc.sv | 36 +++
 rtl/if_block.sv | 96 +++++++++
 3 files changed

// File: rtl/if_block_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_block_pkg;

  // Decode-stage register: PC of the instruction in the decode slot plus its valid flag.
  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
  } de_reg_d;

  // Next-PC select encodings; 6 and 7 fall back to sequential fetch.
  localparam logic [2:0] PC_PLUS4  = 3'd0;
  localparam logic [2:0] PC_JALR   = 3'd1;
  localparam logic [2:0] PC_BRANCH = 3'd2;
  localparam logic [2:0] PC_JAL    = 3'd3;
  localparam logic [2:0] PC_MTVEC  = 3'd4;
  localparam logic [2:0] PC_MEPC   = 3'd5;

  // addi x0,x0,0 -- shown to decode whenever the slot holds no instruction.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_block_next_pc.sv
// Next-PC target mux: picks the redirect source and forces word alignment.
module if_next_pc
  import if_block_pkg::*;
(
  input  logic [2:0]  pc_source,
  input  logic [31:0] pc,
  input  logic [31:0] jalr,
  input  logic [31:0] branch,
  input  logic [31:0] jal,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic [31:0] target
);

  logic [31:0] raw_target;

  // Select the raw target; unused encodings behave as sequential fetch (wraps mod 2^32).
  always_comb begin
    raw_target = pc + 32'd4;
    case (pc_source)
      PC_PLUS4:  raw_target = pc + 32'd4;
      PC_JALR:   raw_target = jalr;
      PC_BRANCH: raw_target = branch;
      PC_JAL:    raw_target = jal;
      PC_MTVEC:  raw_target = mtvec;
      PC_MEPC:   raw_target = mepc;
      default:   raw_target = pc + 32'd4;
    endcase
  end

  // Strip the low two bits so a misaligned redirect still fetches a whole word.
  always_comb begin
    target = align_word(raw_target);
  end

endmodule

// File: rtl/if_block.sv
// Instruction-fetch stage: owns the fetch PC, drives the synchronous
// instruction memory, and presents a stable {de_reg, ir} pair to decode.
module if_block
  import if_block_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = if_block_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [2:0]  pc_source,
  input  logic [31:0] jalr,
  input  logic [31:0] branch,
  input  logic [31:0] jal,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic [31:0] imem_addr,
  output logic        imem_rden,
  input  logic [31:0] imem_data,
  output de_reg_d     de_reg,
  output logic [31:0] ir,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_f;
  logic [31:0] pc_d;
  logic        valid_d;
  logic [31:0] hold_ir;
  logic        holding;
  logic [31:0] target;

  if_next_pc u_next_pc (
    .pc_source (pc_source),
    .pc        (pc_f),
    .jalr      (jalr),
    .branch    (branch),
    .jal       (jal),
    .mtvec     (mtvec),
    .mepc      (mepc),
    .target    (target)
  );

  // Memory port: the fetch PC is the address; reads stay enabled during stalls so
  // the held PC is re-read every cycle and is ready the moment the stall drops.
  always_comb begin
    imem_addr = pc_f;
    imem_rden = ~reset;
  end

  // Pipeline state: flush beats stall beats advance. During a stall the memory
  // output already belongs to the next fetch, so the decode word is captured once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f        <= RESET_VECTOR;
      pc_d        <= 32'd0;
      valid_d     <= 1'b0;
      hold_ir     <= 32'd0;
      holding     <= 1'b0;
      fetch_count <= 32'd0;
    end else if (flush) begin
      pc_f    <= target;
      valid_d <= 1'b0;
      holding <= 1'b0;
    end else if (stall) begin
      if (!holding) begin
        hold_ir <= imem_data;
        holding <= 1'b1;
      end else begin
        hold_ir <= hold_ir;
        holding <= 1'b1;
      end
    end else begin
      pc_d        <= pc_f;
      valid_d     <= 1'b1;
      pc_f        <= target;
      holding     <= 1'b0;
      fetch_count <= fetch_count + 32'd1;
    end
  end

  // Decode outputs: bubble shows a NOP; a stalled slot shows the captured word.
  always_comb begin
    de_reg.pc    = pc_d;
    de_reg.valid = valid_d;
    if (!valid_d) begin
      ir = NOP_INSTR;
    end else if (holding) begin
      ir = hold_ir;
    end else begin
      ir = imem_data;
    end
  end

endmodule
